// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-dump engine: FSM state encoding and
// the default register-file address width.
package reg_dump_pkg;

    // Default address pointer width; the register file holds 2**pw entries.
    localparam int PW_DEFAULT = 4;

    // Dump sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/reg_dump_if.sv
// Signal bundle between the dump engine and its environment: command inputs,
// the register-file read port, the output stream and the status flags.
// The master side is the dump engine; the slave side is the integrator
// (command source, register file and stream consumer).
interface reg_dump_if #(
    parameter int pw = reg_dump_pkg::PW_DEFAULT
);
    // Command
    logic          start;
    logic [pw-1:0] base;
    logic [pw:0]   len;

    // Register-file read port (combinational read)
    logic [pw:0]   rd_addr;
    logic [7:0]    rd_data;

    // Output stream
    logic [7:0]    dout;
    logic [pw-1:0] dout_idx;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;

    // Status
    logic          busy;
    logic          done;

    modport master (
        input  start, base, len, rd_data, dout_ready,
        output rd_addr, dout, dout_idx, dout_valid, dout_last, busy, done
    );

    modport slave (
        output start, base, len, rd_data, dout_ready,
        input  rd_addr, dout, dout_idx, dout_valid, dout_last, busy, done
    );

endinterface

// File: rtl/reg_dump.sv
// Register-dump engine: on start, walks len consecutive register-file entries
// from base (wrapping modulo 2**pw), reads each through the combinational
// read port and presents it on a valid/ready stream, one element per
// READ/SEND pair. A one-cycle done pulse marks the end of every dump,
// including an empty one.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int pw = PW_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    reg_dump_if.master bus
);

    localparam logic [pw:0]   REM_ONE = (pw+1)'(1);
    localparam logic [pw-1:0] IDX_ONE = pw'(1);

    // FSM state
    state_e        state_q, state_d;

    // Walk state: next register to read and elements still to send
    logic [pw-1:0] idx_q, idx_d;
    logic [pw:0]   rem_q, rem_d;

    // Registered outputs
    logic [pw:0]   rd_addr_q, rd_addr_d;
    logic [7:0]    dout_q, dout_d;
    logic [pw-1:0] dout_idx_q, dout_idx_d;
    logic          dout_valid_q, dout_valid_d;
    logic          dout_last_q, dout_last_d;

    // Handshake helpers
    logic          xfer;
    logic          final_elem;

    // An element leaves on an edge where SEND is presenting it and the
    // consumer accepts it.
    assign xfer       = (state_q == SEND) && dout_valid_q && bus.dout_ready;
    assign final_elem = (rem_q == REM_ONE);

    // State register.
    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: empty dumps go straight to FIN; otherwise alternate
    // READ/SEND until the final element is accepted.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (bus.len == '0) ? FIN : READ;
                end
            end
            READ: begin
                state_d = SEND;
            end
            SEND: begin
                if (xfer) begin
                    state_d = final_elem ? FIN : READ;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next values: capture the command in IDLE, register the read
    // data in READ, and advance the walk on each accepted element.
    always_comb begin
        idx_d        = idx_q;
        rem_d        = rem_q;
        rd_addr_d    = rd_addr_q;
        dout_d       = dout_q;
        dout_idx_d   = dout_idx_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        case (state_q)
            IDLE: begin
                // start is ignored outside IDLE, so the captured command
                // cannot be disturbed by a request issued mid-dump.
                if (bus.start && (bus.len != '0)) begin
                    idx_d = bus.base;
                    rem_d = bus.len;
                end
            end
            READ: begin
                rd_addr_d    = {1'b0, idx_q};
                dout_d       = bus.rd_data;
                dout_idx_d   = idx_q;
                dout_valid_d = 1'b1;
                dout_last_d  = final_elem;
            end
            SEND: begin
                if (xfer) begin
                    rem_d        = rem_q - REM_ONE;
                    dout_valid_d = 1'b0;
                    dout_last_d  = 1'b0;
                    if (!final_elem) begin
                        // Natural pw-bit overflow gives the modulo-2**pw wrap.
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; all clear asynchronously so an aborted dump leaves
    // nothing visible on the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q        <= '0;
            rem_q        <= '0;
            rd_addr_q    <= '0;
            dout_q       <= '0;
            dout_idx_q   <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            rem_q        <= rem_d;
            rd_addr_q    <= rd_addr_d;
            dout_q       <= dout_d;
            dout_idx_q   <= dout_idx_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
        end
    end

    // State-decoded outputs: status flags, and the read address, which shows
    // the current index during READ and otherwise holds its last value.
    always_comb begin
        bus.busy    = (state_q != IDLE);
        bus.done    = (state_q == FIN);
        bus.rd_addr = (state_q == READ) ? {1'b0, idx_q} : rd_addr_q;
    end

    assign bus.dout       = dout_q;
    assign bus.dout_idx   = dout_idx_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_last  = dout_last_q;

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: an external register file, a transaction-level model
// (queue of expected elements plus timing rules) checked every cycle, and
// directed scenarios with literal expectations on the observed stream.
module tb_reg_dump;
    import reg_dump_pkg::*;

    localparam int PW = 4;
    localparam int N  = 1 << PW;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    reg_dump_if #(.pw(PW)) bus ();

    reg_dump #(.pw(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // External register file with a combinational read port.
    logic [7:0] regs [N];
    assign bus.rd_data = regs[bus.rd_addr[PW-1:0]];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int idx;
        int data;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    bit    m_busy        = 1'b0;
    int    next_valid_at = 0;
    int    done_at       = -1;
    int    last_rd       = 0;
    int    cyc           = 0;
    bit    exp_valid;
    bit    reading;
    int    exp_rd;

    // Observation logs used by the directed literal checks.
    int beat_log[$];
    int data_log[$];
    int last_log[$];
    int done_cnt    = 0;
    int busy_cycles = 0;

    always @(posedge clk) cyc++;

    // Compare process: outputs are sampled mid-cycle on the falling edge, then
    // the model advances to the state it must show after the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            check("rst_rd_addr", bus.rd_addr, 0);
            check("rst_dout", bus.dout, 0);
            check("rst_dout_idx", bus.dout_idx, 0);
            check("rst_dout_valid", bus.dout_valid, 0);
            check("rst_dout_last", bus.dout_last, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.done, 0);
            exp_q.delete();
            m_busy  = 1'b0;
            done_at = -1;
            last_rd = 0;
        end else begin
            exp_valid = m_busy && (exp_q.size() > 0) && (cyc >= next_valid_at);
            reading   = m_busy && (exp_q.size() > 0) && (cyc == next_valid_at - 1);
            exp_rd    = reading ? exp_q[0].idx : last_rd;

            check("busy", bus.busy, m_busy);
            check("done", bus.done, m_busy && (cyc == done_at));
            check("dout_valid", bus.dout_valid, exp_valid);
            check("rd_addr", bus.rd_addr, exp_rd);
            if (exp_valid) begin
                check("dout", bus.dout, exp_q[0].data);
                check("dout_idx", bus.dout_idx, exp_q[0].idx);
                check("dout_last", bus.dout_last, exp_q[0].last);
            end
            if (reading) last_rd = exp_q[0].idx;

            if (bus.busy) busy_cycles++;
            if (bus.done) done_cnt++;
            if (bus.dout_valid && bus.dout_ready) begin
                beat_log.push_back(int'(bus.dout_idx));
                data_log.push_back(int'(bus.dout));
                if (bus.dout_last) last_log.push_back(int'(bus.dout_idx));
            end

            if (!m_busy) begin
                if (bus.start) begin
                    m_busy = 1'b1;
                    if (bus.len == 0) begin
                        done_at = cyc + 1;
                    end else begin
                        done_at       = -1;
                        next_valid_at = cyc + 2;
                        for (int i = 0; i < int'(bus.len); i++) begin
                            exp_q.push_back('{idx:  (int'(bus.base) + i) % N,
                                              data: int'(regs[(int'(bus.base) + i) % N]),
                                              last: (i == int'(bus.len) - 1)});
                        end
                    end
                end
            end else if (exp_valid && bus.dout_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) done_at = cyc + 1;
                else next_valid_at = cyc + 2;
            end else if (cyc == done_at) begin
                m_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // All helpers are entered just after a rising edge.
    task automatic do_start(input int b, input int l);
        bus.start = 1'b1;
        bus.base  = PW'(b);
        bus.len   = (PW+1)'(l);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_quiet(input int limit);
        int n;
        n = 0;
        while (m_busy && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("dump_timeout", m_busy, 0);
        check("idle_after_dump", bus.busy, 0);
    endtask

    task automatic clear_logs();
        beat_log.delete();
        data_log.delete();
        last_log.delete();
        done_cnt    = 0;
        busy_cycles = 0;
    endtask

    task automatic check_idx(input string name, input int exp[$]);
        check({name, "_count"}, beat_log.size(), exp.size());
        foreach (exp[i]) check(name, (i < beat_log.size()) ? beat_log[i] : -1, exp[i]);
    endtask

    // Watchdog: the run is a few hundred cycles; anything beyond this is a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int e[$];
        int seen;

        for (int i = 0; i < N; i++) regs[i] = 8'(i * 3);
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.base       = '0;
        bus.len        = '0;
        bus.dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Full dump from 0: 16 beats 0,3,..,45, last on 15, one done, 33 busy cycles.
        clear_logs();
        do_start(0, 16);
        wait_quiet(200);
        e = {0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
        check_idx("full_idx", e);
        check("full_data5", data_log.size() > 5 ? data_log[5] : -1, 15);
        check("full_data15", data_log.size() > 15 ? data_log[15] : -1, 45);
        check("full_last_cnt", last_log.size(), 1);
        check("full_last_idx", last_log.size() > 0 ? last_log[0] : -1, 15);
        check("full_done_cnt", done_cnt, 1);
        check("full_busy_cycles", busy_cycles, 33);

        // Wrapping dump: base 14, len 4.
        clear_logs();
        do_start(14, 4);
        wait_quiet(100);
        e = {14, 15, 0, 1};
        check_idx("wrap_idx", e);
        check("wrap_data0", data_log.size() > 0 ? data_log[0] : -1, 42);
        check("wrap_data3", data_log.size() > 3 ? data_log[3] : -1, 3);
        check("wrap_last_idx", last_log.size() > 0 ? last_log[0] : -1, 1);
        check("wrap_busy_cycles", busy_cycles, 9);

        // Empty dump: no beats, done once, busy for one cycle.
        clear_logs();
        do_start(7, 0);
        wait_quiet(20);
        check("empty_beats", beat_log.size(), 0);
        check("empty_done_cnt", done_cnt, 1);
        check("empty_busy_cycles", busy_cycles, 1);

        // Back-pressure: ready low for 5 cycles while beat 2 is presented.
        clear_logs();
        do_start(3, 6);
        repeat (5) @(posedge clk);
        #1 bus.dout_ready = 1'b0;
        check("stall_beat2_valid", bus.dout_valid, 1);
        check("stall_beat2_idx", bus.dout_idx, 5);
        repeat (5) @(posedge clk);
        #1 bus.dout_ready = 1'b1;
        wait_quiet(100);
        e = {3, 4, 5, 6, 7, 8};
        check_idx("stall_idx", e);
        check("stall_done_cnt", done_cnt, 1);
        check("stall_busy_cycles", busy_cycles, 18);

        // Reset during beat 3 of a len=8 dump, then restart straight away.
        clear_logs();
        do_start(2, 8);
        repeat (7) @(posedge clk);
        #3;
        check("pre_rst_valid", bus.dout_valid, 1);
        check("pre_rst_idx", bus.dout_idx, 5);
        reset = 1'b1;
        #1;
        check("async_rst_valid", bus.dout_valid, 0);
        check("async_rst_dout", bus.dout, 0);
        check("async_rst_idx", bus.dout_idx, 0);
        check("async_rst_last", bus.dout_last, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_done", bus.done, 0);
        check("async_rst_rd_addr", bus.rd_addr, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("abort_beats", beat_log.size(), 3);
        check("abort_done_cnt", done_cnt, 0);
        clear_logs();
        do_start(10, 3);
        check("restart_busy", bus.busy, 1);
        wait_quiet(100);
        e = {10, 11, 12};
        check_idx("restart_idx", e);
        check("restart_done_cnt", done_cnt, 1);

        // start while busy is ignored.
        clear_logs();
        do_start(5, 3);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.base  = 4'd0;
        bus.len   = 5'd16;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_quiet(100);
        repeat (3) @(posedge clk);
        #1;
        e = {5, 6, 7};
        check_idx("busy_start_idx", e);
        check("busy_start_done_cnt", done_cnt, 1);
        check("busy_start_busy_cycles", busy_cycles, 7);

        // len = 2**pw from a non-zero base touches every register exactly once.
        clear_logs();
        do_start(9, 16);
        wait_quiet(200);
        seen = 0;
        foreach (beat_log[i]) seen |= (1 << beat_log[i]);
        check("all_regs_count", beat_log.size(), 16);
        check("all_regs_mask", seen, 32'hFFFF);
        check("all_regs_last_idx", last_log.size() > 0 ? last_log[0] : -1, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
